uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: UART_RX_fsm

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single receiver clock, oversampled at Prescale times the bit rate.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port RX_IN, input, 1 bit: serial line, idle high.
REQ-004 SHALL have port PAR_EN, input, 1 bit: 1 means the frame carries a parity bit.
REQ-005 SHALL have port Prescale, input, 6 bits: oversampling ratio; legal values are 8, 16 and 32.
REQ-006 SHALL have ports strt_glitch, par_err and stp_err, inputs, 1 bit each: checker results, valid in the cycle their enable is high.
REQ-007 SHALL have ports edge_cnt (6 bits) and bit_cnt (4 bits), outputs: current oversample edge index and current frame bit index.
REQ-008 SHALL have port dat_samp_en, output, 1 bit: enables the bit sampler.
REQ-009 SHALL have port deser_en, output, 1 bit: one-cycle shift strobe to the deserializer.
REQ-010 SHALL have ports strt_chk_en, par_chk_en and stp_chk_en, outputs, 1 bit each: one-cycle check strobes.
REQ-011 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a good frame.

Function
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY and STOP, with a registered state.
REQ-013 In IDLE, with RX_IN=0 sampled, SHALL move to START next cycle with edge_cnt=0 and bit_cnt=0.
REQ-014 Outside IDLE, edge_cnt SHALL count 0..Prescale-1 and wrap to 0; at each wrap bit_cnt SHALL increment.
REQ-015 "Bit end" means edge_cnt==Prescale-1; every state transition other than IDLE->START SHALL occur only at bit end.
REQ-016 dat_samp_en SHALL be 1 in every state except IDLE.
REQ-017 START: strt_chk_en SHALL be high at bit end; strt_glitch=1 -> IDLE, else -> DATA.
REQ-018 DATA: deser_en SHALL be high at each of the 8 bit ends (bit_cnt 1..8); after bit_cnt 8 -> PARITY if PAR_EN=1, else -> STOP.
REQ-019 PARITY: par_chk_en SHALL be high at bit end; par_err=1 -> IDLE (frame dropped), else -> STOP.
REQ-020 STOP: stp_chk_en SHALL be high at bit end; stp_err=0 -> data_valid pulses that cycle; either way -> IDLE.
REQ-021 On entry to IDLE, counters SHALL clear to 0, and every strobe SHALL be 0 in IDLE.
REQ-022 PAR_EN and Prescale SHALL be sampled only on the IDLE->START transition and held for the whole frame.
REQ-023 A start edge present in the IDLE cycle right after STOP SHALL be accepted, so back-to-back frames are supported.
REQ-024 Illegal state encodings SHALL return to IDLE.

Reset
REQ-025 On RST=0, state SHALL be IDLE asynchronously, and edge_cnt, bit_cnt and all strobes, including data_valid, SHALL be 0.
REQ-026 Reset mid-frame SHALL abort the frame with no data_valid; operation SHALL resume on the first start edge after release.

Structure
REQ-027 The state encoding and the legal Prescale constants (8, 16, 32) SHALL live in the shared UART RX package.
REQ-028 The edge and bit counters SHALL be one sub-module, UART_RX_edge_bit_counter, with enable and clear driven by the FSM.

Verification
REQ-029 Prescale=8, PAR_EN=0, frame 0xA5, good stop: deser_en pulses 8 times, then data_valid pulses once, 80 cycles after the start edge.
REQ-030 Prescale=16, PAR_EN=1, frame 0x3C with even parity correct: par_chk_en pulses once with bit_cnt=9, and data_valid follows at bit_cnt=10.
REQ-031 Forcing par_err=1 at the parity strobe: FSM goes to IDLE, stp_chk_en never pulses, and data_valid stays 0.
REQ-032 Forcing strt_glitch=1 at the start strobe: FSM goes to IDLE after Prescale cycles, deser_en stays 0, and a following valid frame is received.
REQ-033 Asserting RST=0 at bit_cnt=4 of a frame: all outputs read 0 immediately, with no data_valid; the next frame after release is received correctly.
REQ-034 Two back-to-back frames with Prescale=32 and stp_err=0: two data_valid pulses spaced exactly 320 cycles apart.

Source files
------------

// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receiver control path: state encoding,
// legal oversampling ratios and frame-shape constants.
package uart_rx_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  // Bit index of the last data bit; the start bit is index 0.
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  function automatic logic presc_legal(input logic [5:0] presc);
    return (presc == PRESC_8) || (presc == PRESC_16) || (presc == PRESC_32);
  endfunction

  // An unsupported ratio is replaced by the smallest legal one so that the
  // bit-end compare always has a reachable terminal value.
  function automatic logic [5:0] presc_sanitize(input logic [5:0] presc);
    return presc_legal(presc) ? presc : PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter. The edge counter runs
// 0..last_edge and wraps; every wrap advances the bit counter. Clear wins
// over enable.
module uart_rx_edge_bit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [5:0] last_edge,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       bit_end
);

  assign bit_end = (edge_cnt == last_edge);

  // Edge/bit counting with synchronous clear from the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (clr) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (en) begin
      if (bit_end) begin
        edge_cnt <= 6'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver sequencing FSM.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line idle, counters held at 0, waiting for RX_IN low
//   ST_START  | start bit (bit 0); start check strobed at its bit end
//   ST_DATA   | data bits 1..8; deserializer shift strobed at each bit end
//   ST_PARITY | parity bit (bit 9), only when the frame carries parity
//   ST_STOP   | stop bit; stop check and data_valid at its bit end
//
// All transitions except IDLE->START happen at bit end
// (edge_cnt == Prescale-1). Frame format (ratio, parity) is captured on
// the IDLE->START transition and held until the next frame.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid
);

  rx_state_e  state_q;
  rx_state_e  state_d;
  logic [5:0] presc_q;
  logic       par_en_q;
  logic       start_det;
  logic       bit_end;
  logic       cnt_en;
  logic       cnt_clr;
  logic [5:0] last_edge;

  assign start_det = (state_q == ST_IDLE) && !RX_IN;
  assign last_edge = presc_q - 6'd1;
  assign cnt_en    = (state_q != ST_IDLE);
  // Counters sit at zero throughout IDLE and are cleared on the cycle that
  // leaves a frame, so every frame starts from edge 0 / bit 0.
  assign cnt_clr   = (state_q == ST_IDLE) || (state_d == ST_IDLE);

  uart_rx_edge_bit_counter u_cnt (
    .clk       (CLK),
    .rst_n     (RST),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .last_edge (last_edge),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .bit_end   (bit_end)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame format capture on start detection, held for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q  <= PRESC_8;
      par_en_q <= 1'b0;
    end else if (start_det) begin
      presc_q  <= presc_sanitize(Prescale);
      par_en_q <= PAR_EN;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d     = state_q;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        dat_samp_en = 1'b1;
        if (bit_end) begin
          strt_chk_en = 1'b1;
          state_d     = strt_glitch ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        dat_samp_en = 1'b1;
        if (bit_end) begin
          deser_en = 1'b1;
          if (bit_cnt == LAST_DATA_BIT) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        dat_samp_en = 1'b1;
        if (bit_end) begin
          par_chk_en = 1'b1;
          state_d    = par_err ? ST_IDLE : ST_STOP;
        end
      end
      ST_STOP: begin
        dat_samp_en = 1'b1;
        if (bit_end) begin
          stp_chk_en = 1'b1;
          data_valid = !stp_err;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm. A frame-level reference model predicts
// every output in every cycle from the frame position alone.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic       samp;
    logic       deser;
    logic       strt;
    logic       par;
    logic       stp;
    logic       dv;
    logic [5:0] edg;
    logic [3:0] bitc;
  } obs_t;

  typedef struct {
    int   t0;
    int   mism;
    int   first_o;
    obs_t first_obs;
    obs_t first_exp;
    int   deser_n;
    int   strt_n;
    int   par_n;
    int   par_bit;
    int   stp_n;
    int   dv_n;
    int   dv_o;
    int   dv_bit;
    obs_t rst_obs;
  } res_t;

  uart_rx_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic obs_t sample_dut();
    obs_t s;
    s.samp  = dat_samp_en;
    s.deser = deser_en;
    s.strt  = strt_chk_en;
    s.par   = par_chk_en;
    s.stp   = stp_chk_en;
    s.dv    = data_valid;
    s.edg   = edge_cnt;
    s.bitc  = bit_cnt;
    return s;
  endfunction

  // Frame length in bits as seen by the receiver, including early aborts.
  function automatic int frame_bits(bit pe, bit glitch, bit perr);
    if (glitch) return 1;
    if (pe) return perr ? 10 : 11;
    return 10;
  endfunction

  // Expected outputs at cycle offset o, where offset 0 is the idle cycle in
  // which the line is first low. Bit b occupies offsets b*p+1 .. (b+1)*p.
  function automatic obs_t model(int o, int p, bit pe, bit glitch, bit perr, bit serr);
    obs_t m;
    int   nbits;
    int   b;
    int   e;
    m = '0;
    nbits = frame_bits(pe, glitch, perr);
    if (o >= 1 && o <= nbits * p) begin
      b = (o - 1) / p;
      e = (o - 1) % p;
      m.samp = 1'b1;
      m.edg  = 6'(e);
      m.bitc = 4'(b);
      if (e == p - 1) begin
        if (b == 0)            m.strt  = 1'b1;
        else if (b <= 8)       m.deser = 1'b1;
        else if (pe && b == 9) m.par   = 1'b1;
        else begin
          m.stp = 1'b1;
          m.dv  = !serr;
        end
      end
    end
    return m;
  endfunction

  // Serial line level at offset j: start, 8 data LSB first, even parity, stop.
  function automatic logic line_bit(int j, int p, bit pe, logic [7:0] d, bit glitch);
    int idx;
    idx = j / p;
    if (glitch) return (j < p / 2) ? 1'b0 : 1'b1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) return ^d;
    return 1'b1;
  endfunction

  function automatic logic [5:0] rand_presc();
    case ($urandom_range(0, 2))
      0:       return 6'd8;
      1:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame from a negedge in IDLE and records what the DUT did.
  // Returns at the negedge of the idle cycle right after the frame, or
  // (abort_at > 0) 1 ns after pulling reset low at that offset.
  task automatic run_frame(input int p, input bit pe, input logic [7:0] data,
                           input bit glitch, input bit perr, input bit serr,
                           input int abort_at, output res_t r);
    obs_t ob;
    obs_t ex;
    int   last_o;
    r.t0 = cyc; r.mism = 0; r.first_o = -1; r.first_obs = '0; r.first_exp = '0;
    r.deser_n = 0; r.strt_n = 0; r.par_n = 0; r.par_bit = -1; r.stp_n = 0;
    r.dv_n = 0; r.dv_o = -1; r.dv_bit = -1; r.rst_obs = '0;
    Prescale    = 6'(p);
    PAR_EN      = pe;
    strt_glitch = glitch;
    par_err     = perr;
    stp_err     = serr;
    RX_IN       = 1'b0;
    last_o = (abort_at > 0) ? abort_at : frame_bits(pe, glitch, perr) * p;
    for (int o = 0; o <= last_o; o++) begin
      if (abort_at > 0 && o == abort_at) begin
        RST   = 1'b0;
        RX_IN = 1'b1;
        #1;
        r.rst_obs = sample_dut();
        break;
      end
      ob = sample_dut();
      ex = model(o, p, pe, glitch, perr, serr);
      if (ob !== ex) begin
        r.mism++;
        if (r.mism == 1) begin
          r.first_o = o; r.first_obs = ob; r.first_exp = ex;
        end
      end
      if (ob.deser) r.deser_n++;
      if (ob.strt)  r.strt_n++;
      if (ob.par) begin r.par_n++; r.par_bit = int'(ob.bitc); end
      if (ob.stp)   r.stp_n++;
      if (ob.dv) begin r.dv_n++; r.dv_o = o; r.dv_bit = int'(ob.bitc); end
      // Format inputs wander mid-frame; the DUT must ignore them.
      if (o >= 1) begin
        Prescale = rand_presc();
        PAR_EN   = 1'($urandom_range(0, 1));
      end
      RX_IN = line_bit(o + 1, p, pe, data, glitch);
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (sample_dut() !== obs_t'('0)) begin
      bad++; $display("FAIL reset_state: got %h want 0", sample_dut());
    end
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if (sample_dut() !== obs_t'('0)) begin
      bad++; $display("FAIL reset_holds_idle: got %h want 0", sample_dut());
    end
    RX_IN = 1'b1;
    RST   = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic_p8();
    res_t r;
    run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 0, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL p8_frame: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.deser_n !== 8) begin bad++; $display("FAIL p8_deser_count: got %0d want 8", r.deser_n); end
    total++; if (r.strt_n !== 1) begin bad++; $display("FAIL p8_strt_count: got %0d want 1", r.strt_n); end
    total++; if (r.dv_n !== 1) begin bad++; $display("FAIL p8_dv_count: got %0d want 1", r.dv_n); end
    total++; if (r.dv_o !== 80) begin bad++; $display("FAIL p8_dv_latency: got %0d want 80", r.dv_o); end
    idle(3);
  endtask

  task automatic test_parity_p16();
    res_t r;
    run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 0, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL p16_par_frame: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.par_n !== 1) begin bad++; $display("FAIL p16_par_count: got %0d want 1", r.par_n); end
    total++; if (r.par_bit !== 9) begin bad++; $display("FAIL p16_par_bit: got %0d want 9", r.par_bit); end
    total++; if (r.dv_bit !== 10) begin bad++; $display("FAIL p16_dv_bit: got %0d want 10", r.dv_bit); end
    total++; if (r.dv_o !== 176) begin bad++; $display("FAIL p16_dv_latency: got %0d want 176", r.dv_o); end
    idle(2);
  endtask

  task automatic test_par_err();
    res_t r;
    run_frame(int'(rand_presc()), 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 0, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL par_err_frame: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.stp_n !== 0) begin bad++; $display("FAIL par_err_stp: got %0d want 0", r.stp_n); end
    total++; if (r.dv_n !== 0) begin bad++; $display("FAIL par_err_dv: got %0d want 0", r.dv_n); end
    total++; if (sample_dut() !== obs_t'('0)) begin bad++; $display("FAIL par_err_idle: got %h want 0", sample_dut()); end
    idle(2);
  endtask

  task automatic test_glitch();
    res_t r;
    run_frame(16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL glitch_frame: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.deser_n !== 0) begin bad++; $display("FAIL glitch_deser: got %0d want 0", r.deser_n); end
    total++; if (sample_dut() !== obs_t'('0)) begin bad++; $display("FAIL glitch_idle: got %h want 0", sample_dut()); end
    idle(3);
    run_frame(8, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 0, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL glitch_next_frame: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.dv_n !== 1) begin bad++; $display("FAIL glitch_next_dv: got %0d want 1", r.dv_n); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    res_t r;
    run_frame(16, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0, 1'b0, 4 * 16 + 5, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL rstmid_prefix: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.rst_obs !== obs_t'('0)) begin bad++; $display("FAIL rstmid_async: got %h want 0", r.rst_obs); end
    total++; if (r.dv_n !== 0) begin bad++; $display("FAIL rstmid_dv: got %0d want 0", r.dv_n); end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    idle(2);
    total++; if (sample_dut() !== obs_t'('0)) begin bad++; $display("FAIL rstmid_release_idle: got %h want 0", sample_dut()); end
    run_frame(8, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 0, r);
    total++; if (r.mism !== 0) begin bad++; $display("FAIL rstmid_next_frame: %0d bad cycles, first offset %0d got %h want %h", r.mism, r.first_o, r.first_obs, r.first_exp); end
    total++; if (r.dv_n !== 1) begin bad++; $display("FAIL rstmid_next_dv: got %0d want 1", r.dv_n); end
    idle(2);
  endtask

  // Second start edge lands in the idle cycle right after the first stop
  // bit end, so 320 non-valid cycles separate the two data_valid pulses.
  task automatic test_back_to_back();
    res_t r1;
    res_t r2;
    int   gap;
    run_frame(32, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 0, r1);
    run_frame(32, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 0, r2);
    gap = (r2.t0 + r2.dv_o) - (r1.t0 + r1.dv_o) - 1;
    total++; if (r1.mism !== 0 || r2.mism !== 0) begin bad++; $display("FAIL b2b_frames: bad cycles %0d and %0d", r1.mism, r2.mism); end
    total++; if (r1.dv_n !== 1 || r2.dv_n !== 1) begin bad++; $display("FAIL b2b_dv_count: got %0d,%0d want 1,1", r1.dv_n, r2.dv_n); end
    total++; if (gap !== 320) begin bad++; $display("FAIL b2b_spacing: got %0d want 320", gap); end
    idle(2);
  endtask

  task automatic test_random();
    res_t r;
    int   p;
    bit   pe, gl, pr, se;
    int   want_dv;
    for (int k = 0; k < 14; k++) begin
      p  = int'(rand_presc());
      pe = 1'($urandom_range(0, 1));
      gl = ($urandom_range(0, 5) == 0);
      pr = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) == 0);
      want_dv = (!gl && !(pe && pr) && !se) ? 1 : 0;
      run_frame(p, pe, 8'($urandom), gl, pr, se, 0, r);
      total++; if (r.mism !== 0) begin bad++; $display("FAIL rand_frame %0d (p=%0d pe=%0d gl=%0d pr=%0d se=%0d): %0d bad cycles, first offset %0d got %h want %h", k, p, pe, gl, pr, se, r.mism, r.first_o, r.first_obs, r.first_exp); end
      total++; if (r.dv_n !== want_dv) begin bad++; $display("FAIL rand_dv %0d: got %0d want %0d", k, r.dv_n, want_dv); end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic_p8();
    test_parity_p16();
    test_par_err();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
